// File: rtl/axi_lite_rd_slave.sv
// axi_lite_rd_slave: AXI4-Lite read-only responder over a locally written register bank.
// Define AXI_RD_SLV_STATS_EN to add the rd_count/err_count handshake statistics ports.
module axi_lite_rd_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  reg_wr_en,
  input  logic [7:0]            reg_wr_idx,
  input  logic [DATA_WIDTH-1:0] reg_wr_data
`ifdef AXI_RD_SLV_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           err_count
`endif
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
  logic                  hit;
  logic [IW-1:0]         idx;
  assign hit     = addr_q[1:0] == 2'b00 && {2'b00, addr_q[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(NUM_REGS);
  assign idx     = addr_q[IW+1:2];
  assign ARREADY = state_q == IDLE;
  assign RVALID  = state_q == RESP;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  // Counter starts one above RD_LATENCY so RVALID rises RD_LATENCY+2 edges after the AR handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (state_q == IDLE && ARVALID) begin
      addr_d  = ARADDR;
      cnt_d   = 5'(RD_LATENCY + 1);
      state_d = WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q == 5'd0 ? 5'd0 : cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        rdata_d = hit ? bank_q[idx] : '0;
        rresp_d = hit ? 2'b00 : 2'b10;
        state_d = RESP;
      end
    end else if (state_q == RESP && RREADY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else if (reg_wr_en && 32'(reg_wr_idx) < NUM_REGS) begin
      bank_q[reg_wr_idx[IW-1:0]] <= reg_wr_data;
    end
`ifdef AXI_RD_SLV_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_count  <= '0;
      err_count <= '0;
    end else if (RVALID && RREADY) begin
      rd_count  <= rd_count + 16'd1;
      err_count <= err_count + {15'd0, rresp_q == 2'b10};
    end
`endif
endmodule

// File: tb/tb_axi_lite_rd_slave.sv
// tb_axi_lite_rd_slave: randomized AR/R transactions checked against an array model of the bank.
module tb_axi_lite_rd_slave;
  localparam int L = 2;
  localparam int N = 16;
  logic        clk, rst;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
`ifdef AXI_RD_SLV_STATS_EN
  logic [15:0] rd_count, err_count;
`endif
  int checks = 0;
  int errors = 0;
  int rd_n = 0;
  int err_n = 0;
  logic [31:0] mb [N];

  axi_lite_rd_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(N), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data)
`ifdef AXI_RD_SLV_STATS_EN
    , .rd_count(rd_count), .err_count(err_count)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [33:0] exp_rd(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a[31:2] >= N) return {32'h0, 2'b10};
    return {mb[a[5:2]], 2'b00};
  endfunction

  task automatic model_wr(input logic [7:0] i, input logic [31:0] d);
    if (i < N) mb[i[3:0]] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mb[i] = '0;
    rd_n = 0;
    err_n = 0;
  endtask

  task automatic wr(input logic [7:0] i, input logic [31:0] d);
    @(negedge clk);
    reg_wr_en = 1; reg_wr_idx = i; reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 0;
    model_wr(i, d);
  endtask

  // wr_edge counts edges after the AR handshake edge; 0 means no local write during the read.
  task automatic do_read(input string nm, input logic [31:0] a, input int hold,
                         input int wr_edge, input logic [7:0] wi, input logic [31:0] wd);
    int e;
    bit pend;
    logic [31:0] ed;
    logic [1:0] er;
    pend = 0;
    @(negedge clk);
    ARADDR = a; ARVALID = 1; RREADY = 0;
    checks++;
    if (ARREADY !== 1'b1) begin errors++; $display("FAIL %s arready_idle got %b want 1", nm, ARREADY); end
    @(posedge clk);
    #1 ARVALID = 0;
    e = 0;
    while (RVALID !== 1'b1 && e < 40) begin
      if (e + 1 == wr_edge) begin reg_wr_en = 1; reg_wr_idx = wi; reg_wr_data = wd; end
      @(posedge clk);
      e++;
      #1 reg_wr_en = 0;
      if (e == wr_edge) begin
        if (e < L + 2) model_wr(wi, wd);
        else pend = 1;
      end
    end
    {ed, er} = exp_rd(a);
    checks++;
    if (e !== L + 2) begin errors++; $display("FAIL %s latency got %0d edges want %0d", nm, e, L + 2); end
    checks++;
    if (RDATA !== ed || RRESP !== er) begin
      errors++; $display("FAIL %s rdata got %h/%b want %h/%b", nm, RDATA, RRESP, ed, er);
    end
    for (int i = 0; i < hold; i++) begin
      if (e + 1 == wr_edge) begin reg_wr_en = 1; reg_wr_idx = wi; reg_wr_data = wd; end
      @(posedge clk);
      e++;
      #1 reg_wr_en = 0;
      if (e == wr_edge) pend = 1;
      checks++;
      if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== ed || RRESP !== er) begin
        errors++;
        $display("FAIL %s hold%0d got v%b ar%b %h/%b want v1 ar0 %h/%b", nm, i, RVALID, ARREADY, RDATA, RRESP, ed, er);
      end
    end
    RREADY = 1;
    @(posedge clk);
    #1 RREADY = 0;
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL %s after_r got v%b ar%b want v0 ar1", nm, RVALID, ARREADY);
    end
    if (pend) model_wr(wi, wd);
    rd_n++;
    if (er == 2'b10) err_n++;
  endtask

  task automatic test_reset();
    rst = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
    reg_wr_en = 0; reg_wr_idx = 0; reg_wr_data = 0;
    model_clear();
    #1;
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0 || RDATA !== 32'h0 || RRESP !== 2'b00) begin
      errors++; $display("FAIL reset got ar%b v%b %h/%b want ar1 v0 0/00", ARREADY, RVALID, RDATA, RRESP);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_basic();
    wr(8'd3, 32'hDEADBEEF);
    do_read("basic", 32'h0000000C, 0, 0, 0, 0);
    wr(8'd200, 32'hBAD0BAD0);
    do_read("ignored_wr", 32'h00000020, 0, 0, 0, 0);
  endtask

  task automatic test_errors();
    do_read("out_of_range", 32'h00000040, 0, 0, 0, 0);
    do_read("misaligned", 32'h00000006, 0, 0, 0, 0);
    do_read("last_reg", 32'h0000003C, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    wr(8'd1, 32'hA5A5A5A5);
    do_read("backpressure", 32'h00000004, 5, L + 4, 8'd1, 32'h5A5A5A5A);
  endtask

  task automatic test_write_collision();
    wr(8'd1, 32'h11111111);
    do_read("collision", 32'h00000004, 0, L + 2, 8'd1, 32'h22222222);
    do_read("after_collision", 32'h00000004, 0, 0, 0, 0);
    do_read("early_write", 32'h00000004, 1, 1, 8'd1, 32'h33333333);
  endtask

  task automatic test_reset_abort();
    bit bad;
    @(negedge clk);
    ARADDR = 32'h0000000C; ARVALID = 1;
    @(posedge clk);
    #1 ARVALID = 0;
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      errors++; $display("FAIL abort_async got ar%b v%b want ar1 v0", ARREADY, RVALID);
    end
    @(negedge clk);
    rst = 1;
    model_clear();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (RVALID !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_no_rvalid got 1 want 0"); end
    do_read("abort_bank_cleared", 32'h0000000C, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int k;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) wr(8'($urandom_range(0, 19)), $urandom);
      k = $urandom_range(0, 9);
      a = k < 7 ? {26'd0, 4'($urandom_range(0, N - 1)), 2'b00}
        : k == 7 ? {26'd0, 4'($urandom_range(0, N - 1)), 2'($urandom_range(1, 3))}
        : {20'd0, 10'($urandom_range(N, 1023)), 2'b00};
      do_read("random", a, $urandom_range(0, 3), $urandom_range(0, 7),
              {4'd0, a[5:2]}, $urandom);
    end
  endtask

  task automatic test_stats();
`ifdef AXI_RD_SLV_STATS_EN
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_clear();
    wr(8'd2, 32'hCAFEF00D);
    do_read("stats_g0", 32'h00000008, 0, 0, 0, 0);
    do_read("stats_g1", 32'h00000000, 1, 0, 0, 0);
    do_read("stats_e0", 32'h00000100, 0, 0, 0, 0);
    do_read("stats_g2", 32'h00000008, 0, 0, 0, 0);
    do_read("stats_e1", 32'h00000001, 2, 0, 0, 0);
    checks++;
    if (rd_count !== 16'(rd_n) || err_count !== 16'(err_n) || rd_n != 5 || err_n != 2) begin
      errors++; $display("FAIL stats got %0d/%0d want 5/2", rd_count, err_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_write_collision();
    test_random();
    test_reset_abort();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
